// File: rtl/extract_dispatch_pkg.sv
// extract_dispatch_pkg: shared sizes, pktID field position and hold-register FSM states.
package extract_pkg;
    localparam int numExtraction = 8;
    localparam int widthHV = 200;
    localparam int maxOutstanding = 4;
    localparam int widthCnt = 3;
    localparam int pktIdMsb = widthHV - 1;
    localparam int pktIdLsb = widthHV - 8;
    localparam int ptr_w = $clog2(numExtraction);
    localparam int half = numExtraction / 2;
    localparam int half_w = $clog2(half);
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/extract_dispatch_if.sv
// extract_dispatch_if: upstream record handshake plus lane fan-out and credit-return strobes.
interface extract_dispatch_if;
    import extract_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [widthHV-1:0] in_data;
    logic [numExtraction-1:0] lane_valid;
    logic [widthHV-1:0] lane_data;
    logic [numExtraction-1:0] lane_done;
    modport master (output in_valid, in_data, lane_done, input in_ready, lane_valid, lane_data);
    modport slave (input in_valid, in_data, lane_done, output in_ready, lane_valid, lane_data);
endinterface

// File: rtl/extract_dispatch_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first request at or after ptr wins.
module rr_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic         any
);
    logic [N-1:0] rot, gnt_rot;
    // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
    assign rot = N'({req, req} >> ptr);
    assign gnt_rot = rot & (~rot + N'(1));
    assign grant = N'({gnt_rot, gnt_rot} >> (N - int'(ptr)));
    assign any = |req;
endmodule

// File: rtl/extract_dispatch.sv
// extract_dispatch: one-entry hold register dispatching records to credit-limited extraction lanes.
// Define EXTRACT_DISPATCH_ODD_EVEN_EN to alternate the search between even and odd lane groups.
module extract_dispatch
    import extract_pkg::*;
(
    input  logic clk,
    input  logic reset,
    extract_dispatch_if.slave bus,
    output logic busy,
    output logic err_underflow
);
    state_t state;
    logic [widthHV-1:0] hold;
    logic [widthCnt-1:0] cnt [numExtraction];
    logic [numExtraction-1:0] eligible, grant, inc;
    logic any_elig, dispatch_now;
    logic [ptr_w-1:0] chosen;

    always_comb begin
        eligible = '0;
        busy = state == FULL;
        chosen = '0;
        for (int i = 0; i < numExtraction; i++) begin
            eligible[i] = cnt[i] < widthCnt'(maxOutstanding);
            busy = busy | (cnt[i] != '0);
            if (grant[i]) chosen = ptr_w'(i);
        end
    end

    assign dispatch_now = state == FULL && any_elig;
    assign bus.in_ready = state == EMPTY || dispatch_now;
    assign inc = dispatch_now ? grant : '0;

`ifdef EXTRACT_DISPATCH_ODD_EVEN_EN
    logic [half-1:0] req_a, req_b, grant_a, grant_b;
    logic [half_w-1:0] ptr_a, ptr_b, sub_nxt;
    logic any_a, any_b, grp_b, use_b;

    always_comb begin
        req_a = '0;
        req_b = '0;
        grant = '0;
        for (int j = 0; j < half; j++) begin
            req_a[j] = eligible[2*j];
            req_b[j] = eligible[2*j+1];
            grant[2*j] = ~use_b & grant_a[j];
            grant[2*j+1] = use_b & grant_b[j];
        end
    end

    // the preferred group is searched first, the other only when it has no credit
    assign use_b = grp_b ? any_b : ~any_a;
    assign any_elig = any_a | any_b;
    assign sub_nxt = chosen[ptr_w-1:1] == half_w'(half - 1) ? '0 : chosen[ptr_w-1:1] + half_w'(1);

    rr_pick #(.N(half)) u_pick_a (.req(req_a), .ptr(ptr_a), .grant(grant_a), .any(any_a));
    rr_pick #(.N(half)) u_pick_b (.req(req_b), .ptr(ptr_b), .grant(grant_b), .any(any_b));

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_a <= '0;
            ptr_b <= '0;
            grp_b <= 1'b0;
        end else if (dispatch_now) begin
            grp_b <= ~use_b;
            if (use_b) ptr_b <= sub_nxt;
            else ptr_a <= sub_nxt;
        end
    end
`else
    logic [ptr_w-1:0] ptr;

    rr_pick #(.N(numExtraction)) u_pick (.req(eligible), .ptr(ptr), .grant(grant), .any(any_elig));

    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (dispatch_now) ptr <= chosen == ptr_w'(numExtraction - 1) ? '0 : chosen + ptr_w'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            hold <= '0;
            bus.lane_valid <= '0;
            bus.lane_data <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < numExtraction; i++) cnt[i] <= '0;
        end else begin
            bus.lane_valid <= inc;
            if (dispatch_now) bus.lane_data <= hold;
            if (bus.in_valid && bus.in_ready) begin
                hold <= bus.in_data;
                state <= FULL;
            end else if (dispatch_now) state <= EMPTY;
            // a dispatch and a return on the same lane cancel out
            for (int i = 0; i < numExtraction; i++) begin
                if (inc[i] && !bus.lane_done[i]) cnt[i] <= cnt[i] + widthCnt'(1);
                else if (!inc[i] && bus.lane_done[i]) begin
                    if (cnt[i] == '0) err_underflow <= 1'b1;
                    else cnt[i] <= cnt[i] - widthCnt'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_extract_dispatch.sv
// tb_extract_dispatch: scoreboard bench, expected lane/pktID queued at send, popped on each lane strobe.
module tb_extract_dispatch;
    import extract_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, err_underflow;
    int total = 0;
    int bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [widthHV-1:0] d;
    int ord [5];

    extract_dispatch_if bus ();
    extract_dispatch dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy), .err_underflow(err_underflow));

    always #5 clk = ~clk;

    function automatic logic [widthHV-1:0] mk(input logic [7:0] pid);
        return {pid, {24{pid ^ 8'h5a}}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.lane_valid != '0) begin
            if (exp_q.size() == 0) chk("unexpected_strobe", 64'(bus.lane_valid), 64'(0));
            else begin
                e = exp_q.pop_front();
                d = mk(e[7:0]);
                chk("lane", 64'(bus.lane_valid), 64'(8'(1) << e[15:8]));
                chk("pktid", 64'(bus.lane_data[pktIdMsb:pktIdLsb]), 64'(e[7:0]));
                chk("payload", bus.lane_data[63:0], d[63:0]);
            end
        end
    end

    task automatic send(input logic [7:0] pid, input int lane);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = mk(pid);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("accept_timeout", 64'(bus.in_ready), 64'(1));
        if (lane >= 0) exp_q.push_back({8'(lane), pid});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] m);
        bus.lane_done = m;
        @(posedge clk);
        #1 bus.lane_done = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.lane_done = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef EXTRACT_DISPATCH_ODD_EVEN_EN
        ord = '{0, 5, 2, 7, 4};
`else
        ord = '{0, 2, 4, 5, 6};
`endif
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.lane_done = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_lane_valid", 64'(bus.lane_valid), 64'(0));
        chk("rst_lane_data", bus.lane_data[63:0], 64'(0));
        chk("rst_err", 64'(err_underflow), 64'(0));

        // back-to-back records walk lanes 0..7 at one per cycle
        for (int i = 1; i <= 8; i++) send(8'(i), i - 1);
        tick(1);
        chk("thru_last", 64'(bus.lane_valid), 64'(8'h80));
        chk("busy_inflight", 64'(busy), 64'(1));
        drain();

        // exhaust every lane's credit, then free one on lane 5
        do_reset();
        for (int i = 0; i < 32; i++) send(8'(8'h10 + i), i % 8);
        drain();
        send(8'h40, 5);
        tick(3);
        chk("full_in_ready", 64'(bus.in_ready), 64'(0));
        chk("full_no_strobe", 64'(bus.lane_valid), 64'(0));
        chk("full_busy", 64'(busy), 64'(1));
        pulse(8'h20);
        chk("credit_lat0", 64'(bus.lane_valid), 64'(0));
        tick(1);
        chk("credit_lat1", 64'(bus.lane_valid), 64'(8'h20));
        chk("credit_in_ready", 64'(bus.in_ready), 64'(1));
        drain();

        // lanes 1 and 3 saturated, the rest drained
        do_reset();
        for (int i = 0; i < 32; i++) send(8'(8'h60 + i), i % 8);
        drain();
        repeat (4) pulse(8'hf5);
        for (int i = 0; i < 5; i++) send(8'(8'h90 + i), ord[i]);
        drain();

        // return and dispatch on lane 2 in the same edge at cnt 3
        do_reset();
        for (int i = 0; i < 26; i++) send(8'(8'ha0 + i), i % 8);
        send(8'hc0, 2);
        pulse(8'h04);
        for (int i = 0; i < 5; i++) send(8'(8'hc1 + i), 3 + i);
        send(8'hc6, 2);
        drain();
        send(8'hc7, -1);
        tick(3);
        chk("same_edge_in_ready", 64'(bus.in_ready), 64'(0));
        chk("same_edge_busy", 64'(busy), 64'(1));

        // reset with a held record and outstanding credits
        do_reset();
        chk("mid_rst_lane_valid", 64'(bus.lane_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        tick(5);
        chk("mid_rst_quiet", 64'(bus.lane_valid), 64'(0));

        // spurious return on an idle lane
        chk("uf_pre", 64'(err_underflow), 64'(0));
        pulse(8'h40);
        chk("uf_set", 64'(err_underflow), 64'(1));
        chk("uf_busy", 64'(busy), 64'(0));
        tick(3);
        chk("uf_sticky", 64'(err_underflow), 64'(1));
        chk("uf_cnt_zero", 64'(busy), 64'(0));
        send(8'hd0, 0);
        drain();
        chk("uf_sticky2", 64'(err_underflow), 64'(1));
        do_reset();
        chk("uf_clear", 64'(err_underflow), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
